// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a valid/ready transmit FIFO, runtime
// data length (5..DATA_W), optional even/odd parity and 1 or 2 stop bits.
module uart_tx_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         wr_valid_i,
    input  logic [DATA_W-1:0]            wr_data_i,
    output logic                         wr_ready_o,
    input  logic                         tx_en_i,
    input  logic [CNT_W-1:0]             clks_per_bit_i,
    input  logic [$clog2(DATA_W+1)-1:0]  nbits_i,
    input  logic                         parity_en_i,
    input  logic                         parity_odd_i,
    input  logic                         stop2_i,
    output logic                         tx_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level_o,
    output logic                         fifo_empty_o
);

    localparam int unsigned NB_W  = $clog2(DATA_W + 1);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [LVL_W-1:0]  level_q;

    // Frame state and latched per-frame configuration
    state_e            state_q;
    logic              tx_q;
    logic              busy_q;
    logic              done_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [NB_W-1:0]   bit_idx_q;
    logic              stop_hi_q;
    logic [DATA_W-1:0] shift_q;
    logic [CNT_W-1:0]  cpb_q;
    logic [NB_W-1:0]   nbits_q;
    logic              par_en_q;
    logic              par_bit_q;
    logic              stop2_q;

    // Combinational helpers
    logic              full_c;
    logic              empty_c;
    logic              push_c;
    logic              pop_c;
    logic              bit_end_c;
    logic              last_stop_c;
    logic [CNT_W-1:0]  cpb_eff_c;
    logic [NB_W-1:0]   nbits_eff_c;
    logic [DATA_W-1:0] word_c;

    // Handshake, pop decision and sanitised configuration for the next frame
    always_comb begin
        full_c      = (level_q == LVL_W'(DEPTH));
        empty_c     = (level_q == '0);
        push_c      = wr_valid_i && !full_c;
        bit_end_c   = (cnt_q == (cpb_q - CNT_W'(1)));
        last_stop_c = (state_q == S_STOP) && bit_end_c && (!stop2_q || stop_hi_q);
        pop_c       = tx_en_i && !empty_c && ((state_q == S_IDLE) || last_stop_c);
        cpb_eff_c   = (clks_per_bit_i == '0) ? CNT_W'(1) : clks_per_bit_i;
        nbits_eff_c = ((nbits_i == '0) || (nbits_i > NB_W'(DATA_W))) ? NB_W'(DATA_W) : nbits_i;
        word_c      = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            word_c[i] = mem_q[rd_ptr_q][i] && (NB_W'(i) < nbits_eff_c);
        end
    end

    // FIFO storage write; contents need no reset, the level gates every read
    always_ff @(posedge clk_i) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // FIFO pointers and level; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_c && !pop_c) begin
                level_q <= level_q + LVL_W'(1);
            end else if (!push_c && pop_c) begin
                level_q <= level_q - LVL_W'(1);
            end
        end
    end

    // Frame sequencer with registered line, busy and done outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            stop_hi_q <= 1'b0;
            shift_q   <= '0;
            cpb_q     <= CNT_W'(1);
            nbits_q   <= NB_W'(DATA_W);
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
                S_START: begin
                    if (bit_end_c) begin
                        state_q   <= S_DATA;
                        tx_q      <= shift_q[0];
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end_c) begin
                        cnt_q <= '0;
                        if (bit_idx_q == (nbits_q - NB_W'(1))) begin
                            stop_hi_q <= 1'b0;
                            if (par_en_q) begin
                                state_q <= S_PARITY;
                                tx_q    <= par_bit_q;
                            end else begin
                                state_q <= S_STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + NB_W'(1);
                            tx_q      <= shift_q[1];
                            shift_q   <= shift_q >> 1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_PARITY: begin
                    if (bit_end_c) begin
                        state_q   <= S_STOP;
                        tx_q      <= 1'b1;
                        cnt_q     <= '0;
                        stop_hi_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (bit_end_c) begin
                        cnt_q <= '0;
                        if (stop2_q && !stop_hi_q) begin
                            stop_hi_q <= 1'b1;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
            // A pop (from idle or the final stop cycle) starts the next frame back to back
            if (pop_c) begin
                state_q   <= S_START;
                tx_q      <= 1'b0;
                busy_q    <= 1'b1;
                cnt_q     <= '0;
                shift_q   <= word_c;
                cpb_q     <= cpb_eff_c;
                nbits_q   <= nbits_eff_c;
                par_en_q  <= parity_en_i;
                par_bit_q <= (^word_c) ^ parity_odd_i;
                stop2_q   <= stop2_i;
            end
        end
    end

    assign wr_ready_o   = !full_c;
    assign tx_o         = tx_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign fifo_level_o = level_q;
    assign fifo_empty_o = empty_c;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: table of single frames plus hand-written
// sequences for FIFO full, back-to-back frames, reset and config latching.
module tb_uart_tx_fifo;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        wr_valid_i;
    logic [7:0]  wr_data_i;
    logic        wr_ready_o;
    logic        tx_en_i;
    logic [15:0] clks_per_bit_i;
    logic [3:0]  nbits_i;
    logic        parity_en_i;
    logic        parity_odd_i;
    logic        stop2_i;
    logic        tx_o;
    logic        busy_o;
    logic        done_o;
    logic [3:0]  fifo_level_o;
    logic        fifo_empty_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_W(8), .DEPTH(8), .CNT_W(16)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .wr_valid_i     (wr_valid_i),
        .wr_data_i      (wr_data_i),
        .wr_ready_o     (wr_ready_o),
        .tx_en_i        (tx_en_i),
        .clks_per_bit_i (clks_per_bit_i),
        .nbits_i        (nbits_i),
        .parity_en_i    (parity_en_i),
        .parity_odd_i   (parity_odd_i),
        .stop2_i        (stop2_i),
        .tx_o           (tx_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .fifo_level_o   (fifo_level_o),
        .fifo_empty_o   (fifo_empty_o)
    );

    typedef struct {
        logic [15:0] cpb;
        logic [3:0]  nbits;
        logic        par_en;
        logic        par_odd;
        logic        stop2;
        logic [7:0]  data;
        logic [15:0] exp_line;   // bit k = line level during bit period k
        int          exp_bits;
        int          exp_cycles;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_cfg(input logic [15:0] cpb, input logic [3:0] nb, input logic pe,
                           input logic po, input logic s2);
        clks_per_bit_i = cpb;
        nbits_i        = nb;
        parity_en_i    = pe;
        parity_odd_i   = po;
        stop2_i        = s2;
    endtask

    task automatic wait_busy(input string name);
        int n = 0;
        while (!busy_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(busy_o), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        int bad;
        int dones;
        int first_done;
        int cpb_e;
        int f;
        int p;
        logic [7:0]  w;
        logic [15:0] line;

        //         cpb    nb    pe    po    s2    data   line      bits cyc
        vecs[0] = '{16'd4, 4'd8, 1'b0, 1'b0, 1'b0, 8'hA5, 16'h034A, 10, 40};
        vecs[1] = '{16'd2, 4'd7, 1'b1, 1'b0, 1'b1, 8'h35, 16'h066A, 11, 22};
        vecs[2] = '{16'd2, 4'd7, 1'b1, 1'b1, 1'b1, 8'h35, 16'h076A, 11, 22};
        vecs[3] = '{16'd2, 4'd7, 1'b1, 1'b0, 1'b1, 8'hB5, 16'h066A, 11, 22};
        vecs[4] = '{16'd0, 4'd5, 1'b0, 1'b0, 1'b0, 8'h13, 16'h0066,  7,  7};
        vecs[5] = '{16'd3, 4'd0, 1'b1, 1'b1, 1'b0, 8'h01, 16'h0402, 11, 33};

        rst_i      = 1'b1;
        wr_valid_i = 1'b0;
        wr_data_i  = '0;
        tx_en_i    = 1'b0;
        set_cfg(16'd4, 4'd8, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_i = 1'b0;

        // Reset state
        chk("rst_tx", 32'(tx_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_ready", 32'(wr_ready_o), 32'd1);
        chk("rst_level", 32'(fifo_level_o), 32'd0);
        chk("rst_empty", 32'(fifo_empty_o), 32'd1);

        // Single frames from the table
        for (int v = 0; v < NV; v++) begin
            @(negedge clk);
            set_cfg(vecs[v].cpb, vecs[v].nbits, vecs[v].par_en, vecs[v].par_odd, vecs[v].stop2);
            wr_valid_i = 1'b1;
            wr_data_i  = vecs[v].data;
            @(negedge clk);
            wr_valid_i = 1'b0;
            tx_en_i    = 1'b1;
            wait_busy($sformatf("v%0d_start", v));
            tx_en_i = 1'b0;
            cpb_e = vecs[v].exp_cycles / vecs[v].exp_bits;
            line  = vecs[v].exp_line;
            bad = 0;
            cyc = 0;
            while (busy_o && cyc < 200) begin
                if (cyc >= vecs[v].exp_cycles) bad++;
                else if (tx_o !== line[cyc / cpb_e]) bad++;
                if (done_o) bad++;
                cyc++;
                @(negedge clk);
            end
            chk($sformatf("v%0d_len", v), 32'(cyc), 32'(vecs[v].exp_cycles));
            chk($sformatf("v%0d_line", v), 32'(bad), 32'd0);
            chk($sformatf("v%0d_done", v), 32'(done_o), 32'd1);
            @(negedge clk);
            chk($sformatf("v%0d_done_once", v), 32'(done_o), 32'd0);
            chk($sformatf("v%0d_idle_tx", v), 32'(tx_o), 32'd1);
        end

        // Fill past full with tx disabled, then drain as back-to-back frames
        @(negedge clk);
        set_cfg(16'd1, 4'd8, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            wr_valid_i = 1'b1;
            wr_data_i  = 8'h10 + 8'(i);
            @(negedge clk);
            if (i == 6) chk("full_ready_at7", 32'(wr_ready_o), 32'd1);
            if (i == 7) chk("full_ready_at8", 32'(wr_ready_o), 32'd0);
        end
        wr_valid_i = 1'b0;
        chk("full_level", 32'(fifo_level_o), 32'd8);
        tx_en_i = 1'b1;
        @(negedge clk);
        bad = 0;
        dones = 0;
        for (int c = 0; c < 80; c++) begin
            f = c / 10;
            p = c % 10;
            w = 8'h10 + 8'(f);
            if (!busy_o) bad++;
            if (p == 0) begin
                if (tx_o !== 1'b0) bad++;
            end else if (p == 9) begin
                if (tx_o !== 1'b1) bad++;
            end else if (tx_o !== w[p-1]) bad++;
            if (done_o) dones++;
            @(negedge clk);
        end
        if (done_o) dones++;
        tx_en_i = 1'b0;
        chk("b2b_line", 32'(bad), 32'd0);
        chk("b2b_dones", 32'(dones), 32'd8);
        chk("b2b_busy_end", 32'(busy_o), 32'd0);
        chk("b2b_empty", 32'(fifo_empty_o), 32'd1);

        // Full FIFO, write held during a pop, then reset mid-DATA
        set_cfg(16'd4, 4'd8, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            wr_valid_i = 1'b1;
            wr_data_i  = 8'h40 + 8'(i);
            @(negedge clk);
        end
        wr_data_i = 8'h77;
        tx_en_i   = 1'b1;
        @(negedge clk);
        chk("pop_full_level", 32'(fifo_level_o), 32'd7);
        chk("pop_full_ready", 32'(wr_ready_o), 32'd1);
        tx_en_i = 1'b0;
        @(negedge clk);
        wr_valid_i = 1'b0;
        chk("refill_level", 32'(fifo_level_o), 32'd8);
        repeat (4) @(negedge clk);
        chk("mid_data_busy", 32'(busy_o), 32'd1);
        chk("mid_data_bit0", 32'(tx_o), 32'd0);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("abort_tx", 32'(tx_o), 32'd1);
        chk("abort_level", 32'(fifo_level_o), 32'd0);
        chk("abort_busy", 32'(busy_o), 32'd0);
        bad = 0;
        for (int c = 0; c < 60; c++) begin
            if (done_o || busy_o || !tx_o) bad++;
            @(negedge clk);
        end
        chk("abort_quiet", 32'(bad), 32'd0);

        // Config changed right after a frame starts only affects the next frame
        set_cfg(16'd4, 4'd8, 1'b0, 1'b0, 1'b0);
        wr_valid_i = 1'b1;
        wr_data_i  = 8'hA5;
        @(negedge clk);
        wr_data_i  = 8'h3C;
        @(negedge clk);
        wr_valid_i = 1'b0;
        tx_en_i    = 1'b1;
        wait_busy("cfg_start");
        set_cfg(16'd8, 4'd8, 1'b0, 1'b0, 1'b1);
        bad = 0;
        cyc = 0;
        first_done = -1;
        while (busy_o && cyc < 300) begin
            if (cyc < 40) begin
                line = 16'h034A;
                if (tx_o !== line[cyc / 4]) bad++;
            end else if (cyc < 128) begin
                line = 16'h0678;
                if (tx_o !== line[(cyc - 40) / 8]) bad++;
            end else bad++;
            if (done_o && first_done < 0) first_done = cyc;
            cyc++;
            @(negedge clk);
        end
        tx_en_i = 1'b0;
        chk("cfg_first_done", 32'(first_done), 32'd40);
        chk("cfg_total_len", 32'(cyc), 32'd128);
        chk("cfg_line", 32'(bad), 32'd0);
        chk("cfg_last_done", 32'(done_o), 32'd1);

        // tx_en dropped mid-frame: frame completes, nothing further popped
        set_cfg(16'd1, 4'd8, 1'b0, 1'b0, 1'b0);
        wr_valid_i = 1'b1;
        wr_data_i  = 8'h5A;
        @(negedge clk);
        wr_data_i  = 8'hC3;
        @(negedge clk);
        wr_valid_i = 1'b0;
        tx_en_i    = 1'b1;
        wait_busy("txen_start");
        tx_en_i = 1'b0;
        repeat (12) @(negedge clk);
        chk("txen_busy", 32'(busy_o), 32'd0);
        chk("txen_level", 32'(fifo_level_o), 32'd1);
        do_reset();
        chk("final_empty", 32'(fifo_empty_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
